// File: rtl/z80_bus_slave.sv
// z80_bus_slave: Z80 memory/IO bus slave with single-ported CPU access,
// a backdoor write/read port, a write-trace FIFO and a wait-state generator.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   A, cpu_dout        CPU address and write data
//   mreq_n .. rfsh_n   CPU bus strobes (active-low)
//   cpu_di             registered read data to CPU (1-clock latency)
//   wait_n             registered wait request to CPU (active-low)
//   bd_we/addr/wdata   backdoor write port; bd_rdata is a combinational read
//   bd_busy            combinational: backdoor write dropped this clock
//   trc_*              write-trace FIFO (valid/ready head, count, sticky overflow)
//
// Build option: define Z80BUS_IO_EN to add a 256-byte IO space; without it
// IORQ reads return 8'hFF and IORQ writes are ignored.
module z80_bus_slave #(
  parameter int unsigned MEM_AW      = 16,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned TRC_DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [15:0]                A,
  input  logic [7:0]                 cpu_dout,
  input  logic                       mreq_n,
  input  logic                       iorq_n,
  input  logic                       rd_n,
  input  logic                       wr_n,
  input  logic                       rfsh_n,
  output logic [7:0]                 cpu_di,
  output logic                       wait_n,
  input  logic                       bd_we,
  input  logic [15:0]                bd_addr,
  input  logic [7:0]                 bd_wdata,
  output logic [7:0]                 bd_rdata,
  output logic                       bd_busy,
  output logic                       trc_valid,
  input  logic                       trc_ready,
  output logic [15:0]                trc_addr,
  output logic [7:0]                 trc_data,
  output logic [$clog2(TRC_DEPTH):0] trc_count,
  output logic                       trc_ovf
);

  localparam int unsigned MEM_SIZE = 1 << MEM_AW;
  localparam int unsigned PTR_W    = $clog2(TRC_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  logic [7:0]       r_mem [0:MEM_SIZE-1];
  logic [7:0]       r_cpu_di;
  logic             r_prev_mreq_n;
  logic             r_prev_iorq_n;
  logic             r_prev_wr_n;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic             r_wait_n;
  logic [15:0]      r_trc_addr [0:TRC_DEPTH-1];
  logic [7:0]       r_trc_data [0:TRC_DEPTH-1];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  logic             w_mem_commit;
  logic             w_bd_write;
  logic             w_wait_start;
  logic             w_full;
  logic             w_pop;
  logic             w_push_ok;
  logic [7:0]       w_io_rdata;
  logic             w_unused;

  // rd_n is not needed: cpu_di is refreshed every clock regardless of direction
  assign w_unused = ^{rd_n, A, bd_addr};

  // One commit per write access: first clock of mreq_n=0/wr_n=0 outside refresh
  assign w_mem_commit = !reset && !mreq_n && !wr_n && rfsh_n
                        && (r_prev_wr_n || r_prev_mreq_n);
  assign w_bd_write   = !reset && bd_we && !w_mem_commit;
  assign bd_busy      = bd_we && w_mem_commit;
  assign bd_rdata     = r_mem[bd_addr[MEM_AW-1:0]];

`ifdef Z80BUS_IO_EN
  logic [7:0] r_io [0:255];
  logic       w_io_commit;

  assign w_io_commit = !reset && !iorq_n && !wr_n && (r_prev_iorq_n || r_prev_wr_n);
  assign w_io_rdata  = r_io[A[7:0]];

  // IO space: CPU writes only, never traced
  always_ff @(posedge clk) begin
    if (w_io_commit) r_io[A[7:0]] <= cpu_dout;
  end
`else
  assign w_io_rdata = 8'hFF;
`endif

  // Memory array: CPU commit has priority over the backdoor, never reset
  always_ff @(posedge clk) begin
    if (w_mem_commit)    r_mem[A[MEM_AW-1:0]]       <= cpu_dout;
    else if (w_bd_write) r_mem[bd_addr[MEM_AW-1:0]] <= bd_wdata;
  end

  // Read data and strobe edge-detect samples
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpu_di      <= 8'h00;
      r_prev_mreq_n <= 1'b1;
      r_prev_iorq_n <= 1'b1;
      r_prev_wr_n   <= 1'b1;
    end else begin
      r_cpu_di      <= !iorq_n ? w_io_rdata : r_mem[A[MEM_AW-1:0]];
      r_prev_mreq_n <= mreq_n;
      r_prev_iorq_n <= iorq_n;
      r_prev_wr_n   <= wr_n;
    end
  end

  assign w_wait_start = (WAIT_CYCLES != 0) && rfsh_n
                        && ((r_prev_mreq_n && !mreq_n) || (r_prev_iorq_n && !iorq_n));

  // Wait FSM state register; wait_n is registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_wait_n <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_wait_n <= (w_state_nxt != S_WAIT);
    end
  end

  // Wait FSM next state: counter hits 1 on the last wait clock
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_wait_start) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = 4'(WAIT_CYCLES);
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (mreq_n && iorq_n)  w_state_nxt = S_IDLE;
        else if (r_cnt <= 4'd1) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (mreq_n && iorq_n) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_full    = (r_count == CNT_W'(TRC_DEPTH));
  assign w_pop     = !reset && (r_count != '0) && trc_ready;
  // A full FIFO still accepts a push when the head leaves the same clock
  assign w_push_ok = w_mem_commit && (!w_full || w_pop);

  // Trace FIFO storage (not reset; head is stable while empty)
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_trc_addr[r_wr_ptr] <= A;
      r_trc_data[r_wr_ptr] <= cpu_dout;
    end
  end

  // Trace FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push_ok && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push_ok && w_pop) r_count <= r_count - CNT_W'(1);
      if (w_mem_commit && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign cpu_di    = r_cpu_di;
  assign wait_n    = r_wait_n;
  assign trc_valid = (r_count != '0);
  assign trc_addr  = r_trc_addr[r_rd_ptr];
  assign trc_data  = r_trc_data[r_rd_ptr];
  assign trc_count = r_count;
  assign trc_ovf   = r_ovf;

endmodule
